sccb_master_rw: RTL and testbench
=================================

// Module: sccb_master_rw
// PURPOSE
//  Parametrised SCCB (3-wire/2-wire) master for the OV7670_CTRL path; next generation of our write-only master.
//  Adds 2-phase-write/2-phase-read register reads, a programmable SIO_C rate from I_CLK, multi-slave E_N select.
//  Driven by the camera init sequencer; one register transaction per I_START, then waits for I_INTR_CLR.
// PARAMETERS
//  CLK_DIV     250  I_CLK cycles per quarter bit-time (min 2); bit-time = 4*CLK_DIV (100 MHz/250 -> 100 kHz SIO_C)
//  NUM_SLAVES  1    number of SCCB_E_N outputs (1..8); SEL_W = max(1,$clog2(NUM_SLAVES))
// PORTS
//  I_CLK            in     1           system clock; everything below is synchronous to it
//  I_RST_N          in     1           synchronous reset, active low
//  I_START          in     1           start request; sampled only in IDLE
//  I_RW             in     1           0 = 3-phase write, 1 = 2-phase write + 2-phase read
//  I_ID             in     8           slave ID, bit0 ignored (forced 0 for write phases, 1 for read phase)
//  I_SUB            in     8           register sub-address
//  I_WDATA          in     8           write data (ignored when I_RW=1)
//  I_SEL            in     SEL_W       slave select for O_SCCB_E_N
//  I_INTR_CLR       in     1           acknowledges completion; sampled only in INTR
//  O_BUSY           out    1           high from START through GAP
//  O_WAIT_INTR_CLR  out    1           high in INTR
//  O_RDATA          out    8           last read byte; valid while O_WAIT_INTR_CLR after a read
//  O_ACK_ERR        out    1           slave NACK seen in last transaction (ACK_CHECK build only; else tied 0)
//  O_SCCB_E_N       out    NUM_SLAVES  active-low enable; only bit I_SEL (captured) driven low
//  O_SIO_C          out    1           SIO_C, registered push-pull, never a gated I_CLK
//  IO_SIO_D         inout  1           SIO_D; driven 0/1 or released to 'z' (pull-up on board)
// BEHAVIOUR
//  Reset (I_RST_N=0 at a rising edge, any state): state IDLE; O_SIO_C=1; IO_SIO_D='z'; O_SCCB_E_N all 1;
//   O_BUSY=0, O_WAIT_INTR_CLR=0, O_RDATA=8'h00, O_ACK_ERR=0; counters cleared. Mid-transfer reset aborts, no STOP.
//  Quarter tick: counter 0..CLK_DIV-1, tick on wrap; quarter index q=0..3 per bit-time; all bus changes on ticks.
//  IDLE: I_START=1 -> capture I_RW/I_ID/I_SUB/I_WDATA/I_SEL, go START next cycle; inputs ignored afterwards.
//  START (1 bit-time): E_N[sel]=0; SIO_C=1 all q; SIO_D=1 q0-1, 0 q2-3.
//  TX bit (9 per byte, MSB first): SIO_C 0 q0-1, 1 q2-3; SIO_D set at q0; 9th bit (X/ACK) SIO_D='z'.
//  RX byte: SIO_D='z' bits 1-8, sampled at q3 into shift reg; 9th bit master drives NA=1.
//  STOP (1 bit-time): SIO_D=0 q0-1, 1 q2-3; SIO_C 0 q0, 1 q1-3. GAP (1 bit-time): idle bus, E_N all 1.
//  Write sequence: START,ID|0,SUB,WDATA,STOP,GAP,INTR. Read: START,ID|0,SUB,STOP,GAP,START,ID|1,RX,STOP,GAP,INTR.
//  O_BUSY duration exactly: write 30*4*CLK_DIV cycles; read 42*4*CLK_DIV cycles.
//  INTR: O_WAIT_INTR_CLR=1, bus idle; I_INTR_CLR=1 -> IDLE next cycle. I_START in same cycle is ignored.
//  O_RDATA updated at the end of RX byte 8th-bit q3; unchanged by write transactions.
// CONFIGURATION
//  SCCB_ACK_CHECK_EN defined: sample SIO_D at q3 of every 9th TX bit; 1 -> O_ACK_ERR=1, skip to STOP next bit-time,
//   then GAP/INTR as normal; O_ACK_ERR cleared on next I_START capture.
//  Undefined: 9th bit is don't-care per SCCB, never sampled; O_ACK_ERR constant 0.
// STRUCTURE
//  Shared header sccb_defs.vh: state encodings (IDLE,START,TX,RX,STOP,GAP,INTR), quarter indices, SCCB_RD/WR bit.
//  Sub-module sccb_bit_timer: CLK_DIV counter -> o_tick, o_q[1:0], o_bit_end; cleared on IDLE or reset.
//  Top: FSM + phase counter (byte index, bit 0..8) + TX/RX shift regs + registered SIO_C/SIO_D/OE.
// TESTING (sim CLK_DIV=4, SCCB slave BFM on IO_SIO_D with pull-up)
//  Write ID=8'h42 SUB=8'h12 WDATA=8'h80 -> BFM logs 42,12,80; O_BUSY high 480 cycles; O_WAIT_INTR_CLR until I_INTR_CLR.
//  Read ID=8'h43 SUB=8'h0A, BFM returns 8'h76 -> BFM sees 42,0A then 43; O_RDATA=8'h76; master NA bit = 1; 672 cycles.
//  ACK_CHECK build, BFM NACKs ID -> O_ACK_ERR=1, STOP after ID byte; next good write clears O_ACK_ERR.
//  I_RST_N=0 during SUB bit 5 -> next edge O_SIO_C=1, IO_SIO_D='z', E_N all 1, O_BUSY=0; new write then completes.
//  I_START pulsed while busy and with I_INTR_CLR in INTR -> ignored; exactly one transaction observed.
//  NUM_SLAVES=3, I_SEL=2 -> only O_SCCB_E_N[2] low, START..STOP; E_N=3'b111 in GAP/INTR.

Source files
------------

// File: rtl/sccb_master_rw_pkg.sv
// Shared definitions for the SCCB read/write master.
// Holds the FSM state encoding, quarter-index names, the R/W bit values and a
// helper that sizes the slave-select field.
package sccb_master_rw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StTx,
    StRx,
    StStop,
    StGap,
    StIntr
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic SccbWr = 1'b0;
  localparam logic SccbRd = 1'b1;

  // Bit index of the 9th (X / ACK / NA) bit of a byte.
  localparam logic [3:0] AckBit = 4'd8;

  function automatic int unsigned sel_width(int unsigned num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/sccb_master_rw_if.sv
// Request/response and SCCB clock/enable bundle of the SCCB master.
// master modport: view of the SCCB master itself; slave modport: view of the
// requester (camera init sequencer).
//   start, rw, id, sub, wdata, sel, intr_clr : request side, into the master
//   busy, wait_intr_clr, rdata, ack_err      : status, out of the master
//   sccb_e_n, sio_c                          : SCCB enable and clock pins
// SIO_D is bidirectional and is a plain inout port of the top module.
interface sccb_master_rw_if
  import sccb_master_rw_pkg::*;
#(
  parameter int unsigned NumSlaves = 1
);
  localparam int unsigned SelW = sel_width(NumSlaves);

  logic                 start;
  logic                 rw;
  logic [7:0]           id;
  logic [7:0]           sub;
  logic [7:0]           wdata;
  logic [SelW-1:0]      sel;
  logic                 intr_clr;
  logic                 busy;
  logic                 wait_intr_clr;
  logic [7:0]           rdata;
  logic                 ack_err;
  logic [NumSlaves-1:0] sccb_e_n;
  logic                 sio_c;

  modport master (
    input  start, rw, id, sub, wdata, sel, intr_clr,
    output busy, wait_intr_clr, rdata, ack_err, sccb_e_n, sio_c
  );

  modport slave (
    output start, rw, id, sub, wdata, sel, intr_clr,
    input  busy, wait_intr_clr, rdata, ack_err, sccb_e_n, sio_c
  );

endinterface

// File: rtl/sccb_master_rw_bit_timer.sv
// Quarter bit-time generator for the SCCB master.
// Counts ClkDiv clock cycles per quarter and four quarters per bit-time.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : holds the timer at the start of a bit-time
//   q          : current quarter index 0..3
//   bit_end    : high in the last cycle of quarter 3
module sccb_master_rw_bit_timer #(
  parameter int unsigned ClkDiv = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic [1:0] q,
  output logic       bit_end
);
  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      q_q;
  logic            tick;

  assign tick = (cnt_q == CntW'(ClkDiv - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
      q_q   <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      q_q   <= q_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign q       = q_q;
  assign bit_end = tick && (q_q == 2'd3);

endmodule

// File: rtl/sccb_master_rw.sv
// SCCB master with 3-phase writes and 2-phase-write + 2-phase-read reads.
// One register transaction per start request, then waits for intr_clr.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/status/SIO_C/E_N bundle (master modport)
//   sio_d      : SIO_D, driven 0/1 or released (board pull-up)
// Optional build macro SCCB_ACK_CHECK_EN: samples the slave ACK bit, flags a
// NACK on ack_err and cuts the transaction short with a STOP.
// Bus outputs are registered from the decoded state, so pins trail the FSM
// by one clock; all bit-times keep their full length.
module sccb_master_rw
  import sccb_master_rw_pkg::*;
#(
  parameter int unsigned ClkDiv    = 250,
  parameter int unsigned NumSlaves = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sccb_master_rw_if.master      bus,
  inout  wire                   sio_d
);
  localparam int unsigned SelW = sel_width(NumSlaves);

  state_e          state_q, state_d;
  logic            rw_q, rw_d, rd_phase_q, rd_phase_d;
  logic [7:0]      id_q, id_d, sub_q, sub_d, wdata_q, wdata_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [1:0]      byte_q, byte_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      tx_sr_q, tx_sr_d, rdata_q, rdata_d;
  logic [6:0]      rx_sr_q, rx_sr_d;
  logic                 sio_c_q, sio_c_d, sio_d_q, sio_d_d, sio_oe_q, sio_oe_d;
  logic [NumSlaves-1:0] e_n_q, e_n_d;
  logic            e_n_active, nack_seen, sio_d_in;
  logic [1:0]      q_idx;
  logic            bit_end;

`ifdef SCCB_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign nack_seen   = ack_err_q;
  assign bus.ack_err = ack_err_q;
`else
  assign nack_seen   = 1'b0;
  assign bus.ack_err = 1'b0;
`endif

  sccb_master_rw_bit_timer #(
    .ClkDiv (ClkDiv)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == StIdle),
    .q       (q_idx),
    .bit_end (bit_end)
  );

  assign sio_d_in = sio_d;
  assign sio_d    = sio_oe_q ? sio_d_q : 1'bz;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    id_d       = id_q;
    sub_d      = sub_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    rd_phase_d = rd_phase_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rdata_d    = rdata_q;
`ifdef SCCB_ACK_CHECK_EN
    ack_err_d  = ack_err_q;
`endif
    unique case (state_q)
      StIdle: if (bus.start) begin
        rw_d       = bus.rw;
        id_d       = bus.id;
        sub_d      = bus.sub;
        wdata_d    = bus.wdata;
        sel_d      = bus.sel;
        rd_phase_d = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        ack_err_d  = 1'b0;
`endif
        state_d    = StStart;
      end
      StStart: if (bit_end) begin
        state_d = StTx;
        bit_d   = '0;
        byte_d  = '0;
        // Slave ID with the R/W bit: write in the first phase, read in the second.
        tx_sr_d = (id_q & 8'hFE) | {7'd0, rd_phase_q};
      end
      StTx: if (bit_end) begin
        if (bit_q != AckBit) begin
          bit_d   = bit_q + 4'd1;
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end else begin
          bit_d  = '0;
          byte_d = byte_q + 2'd1;
          if (rd_phase_q) begin
            state_d = StRx;
          end else if (byte_q == 2'd0) begin
            tx_sr_d = sub_q;
          end else if (byte_q == 2'd1 && rw_q == SccbWr) begin
            tx_sr_d = wdata_q;
          end else begin
            state_d = StStop;
          end
`ifdef SCCB_ACK_CHECK_EN
          if (sio_d_in) begin
            ack_err_d = 1'b1;
            state_d   = StStop;
          end
`endif
        end
      end
      StRx: if (bit_end) begin
        if (bit_q != AckBit) begin
          bit_d   = bit_q + 4'd1;
          rx_sr_d = {rx_sr_q[5:0], sio_d_in};
          if (bit_q == 4'd7) rdata_d = {rx_sr_q, sio_d_in};
        end else begin
          state_d = StStop;
        end
      end
      StStop: if (bit_end) state_d = StGap;
      StGap: if (bit_end) begin
        if (rw_q == SccbRd && !rd_phase_q && !nack_seen) begin
          rd_phase_d = 1'b1;
          state_d    = StStart;
        end else begin
          state_d = StIntr;
        end
      end
      StIntr: if (bus.intr_clr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values for the current bit-time and quarter; registered below.
  always_comb begin
    sio_c_d    = 1'b1;
    sio_d_d    = 1'b1;
    sio_oe_d   = 1'b0;
    e_n_active = 1'b0;
    unique case (state_q)
      StStart: begin
        e_n_active = 1'b1;
        sio_oe_d   = 1'b1;
        sio_d_d    = ~q_idx[1];
      end
      StTx: begin
        e_n_active = 1'b1;
        sio_c_d    = q_idx[1];
        sio_oe_d   = (bit_q != AckBit);
        sio_d_d    = tx_sr_q[7];
      end
      StRx: begin
        // Release for data bits, drive NA=1 on the 9th bit.
        e_n_active = 1'b1;
        sio_c_d    = q_idx[1];
        sio_oe_d   = (bit_q == AckBit);
      end
      StStop: begin
        e_n_active = 1'b1;
        sio_c_d    = (q_idx != Q0);
        sio_oe_d   = 1'b1;
        sio_d_d    = q_idx[1];
      end
      default: ;
    endcase
    e_n_d = '1;
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      if (e_n_active && sel_q == SelW'(i)) e_n_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rw_q       <= 1'b0;
      id_q       <= '0;
      sub_q      <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rd_phase_q <= 1'b0;
      byte_q     <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rdata_q    <= '0;
      sio_c_q    <= 1'b1;
      sio_d_q    <= 1'b1;
      sio_oe_q   <= 1'b0;
      e_n_q      <= '1;
`ifdef SCCB_ACK_CHECK_EN
      ack_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      id_q       <= id_d;
      sub_q      <= sub_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rd_phase_q <= rd_phase_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rdata_q    <= rdata_d;
      sio_c_q    <= sio_c_d;
      sio_d_q    <= sio_d_d;
      sio_oe_q   <= sio_oe_d;
      e_n_q      <= e_n_d;
`ifdef SCCB_ACK_CHECK_EN
      ack_err_q  <= ack_err_d;
`endif
    end
  end

  assign bus.busy          = state_q inside {StStart, StTx, StRx, StStop, StGap};
  assign bus.wait_intr_clr = (state_q == StIntr);
  assign bus.rdata         = rdata_q;
  assign bus.sccb_e_n      = e_n_q;
  assign bus.sio_c         = sio_c_q;

endmodule

// File: tb/tb_sccb_master_rw.sv
// Bench for sccb_master_rw: behavioural SCCB slave on SIO_D with pull-up,
// randomised write/read transactions checked against a phase-count model.
module tb_sccb_master_rw;
  import sccb_master_rw_pkg::*;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned NumSlaves = 3;
  localparam int unsigned SelW      = sel_width(NumSlaves);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_master_rw_if #(.NumSlaves(NumSlaves)) bus ();
  wire sio_d;
  logic bfm_low = 1'b0;
  pullup (sio_d);
  assign sio_d = bfm_low ? 1'b0 : 1'bz;

  sccb_master_rw #(
    .ClkDiv    (ClkDiv),
    .NumSlaves (NumSlaves)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sio_d (sio_d)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural SCCB slave: logs written bytes, ACKs, returns rd_byte on reads.
  logic [7:0] log_q[$];
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] sh = 8'h00;
  logic       bfm_nack = 1'b0;
  logic       na_seen = 1'b0;
  logic       reading = 1'b0;
  logic       prev_c = 1'b1, prev_d = 1'b1;
  int         bcnt = 0, nbyte = 0;

  always @(negedge clk) begin
    logic c, d;
    c = bus.sio_c;
    d = sio_d;
    if (prev_c && c && prev_d && !d) begin
      bcnt = 0; nbyte = 0; reading = 1'b0; bfm_low = 1'b0;
    end else if (prev_c && c && !prev_d && d) begin
      bcnt = 0; reading = 1'b0; bfm_low = 1'b0;
    end else if (!prev_c && c) begin
      if (!reading && bcnt < 8) sh = {sh[6:0], d};
      bcnt++;
      if (bcnt == 8 && !reading) log_q.push_back(sh);
      if (bcnt == 9) begin
        if (reading) begin
          na_seen = d;
          reading = 1'b0;
        end else if (nbyte == 0 && sh[0]) begin
          reading = 1'b1;
        end
        nbyte++;
        bcnt = 0;
      end
    end else if (prev_c && !c) begin
      if (reading) bfm_low = (bcnt < 8) && !rd_byte[7-bcnt];
      else bfm_low = (bcnt == 8) && !bfm_nack;
    end
    prev_c = c;
    prev_d = d;
  end

  logic [7:0] exp_rdata = 8'h00;

  task automatic run_txn(input logic rw, input logic [7:0] id, input logic [7:0] sub,
                         input logic [7:0] wdata, input int unsigned sel,
                         input logic [7:0] rd_val);
    logic [7:0] exp_q[$];
    logic [NumSlaves-1:0] en_sel;
    int unsigned nbytes, nsegs, exp_bits, busy_cnt, en_low, en_bad, cyc;
    // Model: each START..GAP segment costs 3 bit-times, each byte 9.
    exp_q.push_back(id & 8'hFE);
    if (bfm_nack) begin
      nbytes = 1; nsegs = 1;
    end else begin
      exp_q.push_back(sub);
      exp_q.push_back(rw ? (id | 8'h01) : wdata);
      nbytes = rw ? 4 : 3;
      nsegs  = rw ? 2 : 1;
    end
    exp_bits = nbytes * 9 + nsegs * 3;
    en_sel   = ~(NumSlaves'(1) << sel);
    rd_byte  = rd_val;
    na_seen  = 1'b0;
    log_q.delete();

    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.id = id; bus.sub = sub; bus.wdata = wdata;
    bus.sel = SelW'(sel);
    @(negedge clk);
    bus.start = 1'b0; bus.rw = ~rw; bus.id = 8'($urandom); bus.sub = 8'($urandom);
    bus.wdata = 8'($urandom); bus.sel = SelW'($urandom_range(0, NumSlaves - 1));
    busy_cnt = 0; en_low = 0; en_bad = 0; cyc = 0;
    while (!bus.wait_intr_clr && cyc < 5000) begin
      if (bus.busy) busy_cnt++;
      if (bus.sccb_e_n == en_sel) en_low++;
      else if (bus.sccb_e_n != '1) en_bad++;
      bus.start = (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_eq("done", 32'(bus.wait_intr_clr), 32'd1);
    check_eq("busy_cycles", busy_cnt, exp_bits * 4 * ClkDiv);
    check_eq("en_low_cycles", en_low, (exp_bits - nsegs) * 4 * ClkDiv);
    check_eq("en_bad", en_bad, 0);
    check_eq("intr_en_n", 32'(bus.sccb_e_n), 32'((1 << NumSlaves) - 1));
    check_eq("nbytes", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("byte%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
    if (rw && !bfm_nack) begin
      exp_rdata = rd_val;
      check_eq("na_bit", 32'(na_seen), 32'd1);
    end
    check_eq("rdata", 32'(bus.rdata), 32'(exp_rdata));
    check_eq("ack_err", 32'(bus.ack_err), 32'(bfm_nack));
    repeat (4) @(negedge clk);
    check_eq("wait_hold", 32'(bus.wait_intr_clr), 32'd1);
    bus.intr_clr = 1'b1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.intr_clr = 1'b0;
    bus.start    = 1'b0;
    check_eq("wait_clr", 32'(bus.wait_intr_clr), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("no_retrigger", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.id = '0; bus.sub = '0; bus.wdata = '0;
    bus.sel = '0; bus.intr_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sio_c", 32'(bus.sio_c), 32'd1);
    check_eq("rst_sio_d", 32'(sio_d), 32'd1);
    check_eq("rst_en_n", 32'(bus.sccb_e_n), 32'h7);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_wait", 32'(bus.wait_intr_clr), 32'd0);
    check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
    check_eq("rst_ack_err", 32'(bus.ack_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1'b0, 8'h42, 8'h12, 8'h80, 0, 8'h00);
    run_txn(1'b1, 8'h43, 8'h0A, 8'h00, 2, 8'h76);
`ifdef SCCB_ACK_CHECK_EN
    bfm_nack = 1'b1;
    run_txn(1'b0, 8'h42, 8'h12, 8'h80, 1, 8'h00);
    bfm_nack = 1'b0;
    run_txn(1'b0, 8'h42, 8'h13, 8'h01, 1, 8'h00);
`endif
    for (int n = 0; n < 8; n++)
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, NumSlaves - 1), 8'($urandom));

    // Abort a write during SUB bit 5.
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.id = 8'h42; bus.sub = 8'h12; bus.wdata = 8'h80;
    bus.sel = SelW'(1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15 * 4 * ClkDiv + 6) @(negedge clk);
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_sio_c", 32'(bus.sio_c), 32'd1);
    check_eq("abort_sio_d", 32'(sio_d), 32'd1);
    check_eq("abort_en_n", 32'(bus.sccb_e_n), 32'h7);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_rdata", 32'(bus.rdata), 32'd0);
    exp_rdata = 8'h00;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
